// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: a 2^FIFO_AW-deep byte FIFO feeds a 16x-oversampled serializer.
// Latency: write-to-start-bit is 2 clocks when the FIFO is empty and the line is idle.
// Backpressure: none; a write while full is dropped and the sticky overflow flag is set.
//
// Ports:
//   clk_50mhz, rst      system clock, asynchronous active-high reset
//   divisor             clocks per oversample tick (0 behaves as 1), sampled at each pop
//   wr_en, wr_data      single-cycle push strobe and byte
//   full, empty, count  FIFO status
//   overflow            sticky dropped-write flag
//   busy, tx_done       serializer active / one-cycle end-of-stop-bit pulse
//   uart_tx             registered serial line, idle high
module uart_tx_buffered #(
    parameter int FIFO_AW = 4
) (
    input  logic               clk_50mhz,
    input  logic               rst,
    input  logic [15:0]        divisor,
    input  logic               wr_en,
    input  logic [7:0]         wr_data,
    output logic               full,
    output logic               empty,
    output logic [FIFO_AW:0]   count,
    output logic               overflow,
    output logic               busy,
    output logic               tx_done,
    output logic               uart_tx
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] DEPTH_C = {1'b1, {FIFO_AW{1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // FIFO storage and bookkeeping
    logic [7:0]         mem_q [DEPTH];
    logic [FIFO_AW-1:0] wptr_q;
    logic [FIFO_AW-1:0] rptr_q;
    logic [FIFO_AW:0]   count_q;
    logic [FIFO_AW:0]   count_d;
    logic               overflow_q;

    // Serializer state
    state_t      state_q;
    logic [7:0]  shift_q;
    logic [2:0]  bit_idx_q;
    logic [15:0] div_l_q;
    logic [15:0] div_cnt_q;
    logic [3:0]  tick_cnt_q;
    logic        tx_q;
    logic        tx_done_q;

    logic        push;
    logic        pop;
    logic [15:0] div_eff;
    logic        tick;
    logic        bit_end;
    logic [15:0] div_cnt_nxt;
    logic [3:0]  tick_cnt_nxt;
    logic        stop_last_nxt;

    assign push    = wr_en && (count_q != DEPTH_C);
    assign pop     = (state_q == IDLE) && (count_q != '0);
    assign div_eff = (divisor == 16'd0) ? 16'd1 : divisor;

    // Oversample tick when the down-counter has reached zero; a bit period
    // ends on the 16th tick.
    assign tick         = (div_cnt_q == 16'd0);
    assign bit_end      = tick && (tick_cnt_q == 4'hF);
    assign div_cnt_nxt  = tick ? (div_l_q - 16'd1) : (div_cnt_q - 16'd1);
    assign tick_cnt_nxt = tick_cnt_q + {3'b000, tick};

    // tx_done is registered, so it is raised one edge early: when the counters
    // about to be loaded describe the final clock of the stop bit.
    assign stop_last_nxt = (state_q == STOP) && !bit_end &&
                           (div_cnt_nxt == 16'd0) && (tick_cnt_nxt == 4'hF);

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage needs no reset; discarding contents is done by clearing pointers.
    always_ff @(posedge clk_50mhz) begin
        if (push) begin
            mem_q[wptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk_50mhz or posedge rst) begin
        if (rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            count_q <= count_d;
            if (push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            if (wr_en && !push) begin
                overflow_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_50mhz or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            shift_q    <= 8'h00;
            bit_idx_q  <= 3'd0;
            div_l_q    <= 16'd1;
            div_cnt_q  <= 16'd0;
            tick_cnt_q <= 4'd0;
            tx_q       <= 1'b1;
            tx_done_q  <= 1'b0;
        end else begin
            tx_done_q <= stop_last_nxt;
            case (state_q)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (pop) begin
                        shift_q    <= mem_q[rptr_q];
                        div_l_q    <= div_eff;
                        div_cnt_q  <= div_eff - 16'd1;
                        tick_cnt_q <= 4'd0;
                        bit_idx_q  <= 3'd0;
                        tx_q       <= 1'b0;
                        state_q    <= START;
                    end
                end
                default: begin
                    div_cnt_q  <= div_cnt_nxt;
                    tick_cnt_q <= tick_cnt_nxt;
                    if (bit_end) begin
                        case (state_q)
                            START: begin
                                state_q   <= DATA;
                                bit_idx_q <= 3'd0;
                                tx_q      <= shift_q[0];
                            end
                            DATA: begin
                                if (bit_idx_q == 3'd7) begin
                                    state_q <= STOP;
                                    tx_q    <= 1'b1;
                                end else begin
                                    // Next bit on the line is the one that
                                    // becomes shift[0] after this shift.
                                    shift_q   <= {1'b0, shift_q[7:1]};
                                    bit_idx_q <= bit_idx_q + 3'd1;
                                    tx_q      <= shift_q[1];
                                end
                            end
                            default: begin
                                state_q <= IDLE;
                                tx_q    <= 1'b1;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign full     = (count_q == DEPTH_C);
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign overflow = overflow_q;
    assign busy     = (state_q != IDLE);
    assign tx_done  = tx_done_q;
    assign uart_tx  = tx_q;

endmodule

// File: doc/uart_tx_buffered.md
# uart_tx_buffered

Buffered 8N1 UART transmitter: the transmit counterpart to the board's UART receive path. Bytes arrive from the MIO bus side through a single-cycle write strobe and are queued in a small FIFO. A serializer then drives `uart_tx` at a baud rate set by a 16x-oversample divisor, the same convention as the receiver (divisor 52 at 50 MHz gives 60.1 kbaud). Status outputs let the CPU poll for space and completion.

## Interface
- `FIFO_AW`, default 4: FIFO address width; depth = 2^FIFO_AW = 16 entries.
- `clk_50mhz`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `divisor`  in  16  clocks per oversample tick. 0 is treated as 1.
- `wr_en`  in  1  push strobe; one byte per cycle.
- `wr_data`  in  8  byte to queue.
- `full`  out  1  FIFO holds 2^FIFO_AW entries.
- `empty`  out  1  FIFO holds 0 entries.
- `count`  out  FIFO_AW+1  current FIFO occupancy.
- `overflow`  out  1  sticky; set when a write is dropped; cleared only by `rst`.
- `busy`  out  1  serializer not in IDLE.
- `tx_done`  out  1  one-cycle pulse at the end of each stop bit.
- `uart_tx`  out  1  serial line, idle high.

## Operation
- **FIFO.** Circular buffer with FIFO_AW-bit read/write pointers that wrap modulo depth.
  - A push is accepted iff `wr_en && !full` at the clock edge. Otherwise the byte is dropped and `overflow` is set.
  - A pop occurs only in IDLE when `!empty`.
  - Simultaneous push and pop: `count` is unchanged. Pointer wrap needs no special case.
- **Tick generator.** Down-counter is loaded with `div_l-1`, where `div_l` is the divisor latched at the pop (0 mapped to 1). It emits a tick when it reaches 0 and reloads. A 4-bit sub-counter counts ticks; one bit period = 16 ticks = 16*div_l clocks.
- **FSM states:**
  - IDLE: `uart_tx`=1. If `!empty`, pop the head into the shift register, latch `divisor`, clear the counters, and go to START.
  - START: `uart_tx`=0 for one bit period, then go to DATA with bit index 0.
  - DATA: `uart_tx` = shift[0], sending LSB first. After each bit period, shift right. After bit 7, go to STOP.
  - STOP: `uart_tx`=1 for one bit period. On its last cycle assert `tx_done` and go to IDLE.
- `busy` = (state != IDLE).
- `uart_tx` is registered and is glitch-free.
- A change to `divisor` mid-frame has no effect until the next pop.
- **Reset, including mid-frame:** `uart_tx`=1, `full`=0, `empty`=1, `count`=0, `overflow`=0, `busy`=0, `tx_done`=0. State goes to IDLE, pointers and counters clear, and FIFO contents are discarded. No partial frame resumes.

## Timing
- Write at edge N into an empty FIFO while IDLE:
  - `empty` falls after edge N.
  - Pop occurs at edge N+1; `uart_tx` falls after edge N+1.
  - Write-to-start-bit latency is 2 clocks.
- Frame length is 160*div_l clocks from the start-bit falling edge to the end of the stop bit. `tx_done` is high during the final clock of STOP.
- Back-to-back frames: the stop bit plus 1 IDLE clock gives 16*div_l+1 high clocks between frames.
- Status outputs (`full`, `empty`, `count`, `overflow`) are registered and update on the edge following the push or pop.

## Test plan
- **Reset.** Assert `rst` mid-cycle -> all outputs immediately at their reset values (`uart_tx`=1, `empty`=1, `count`=0). Then hold 100 clocks with no writes -> `uart_tx` stays 1 and `busy`=0.
- **Single byte.** Divisor 52; write 0xA5 -> `uart_tx` falls 2 clocks after the write edge.
  - Line pattern is 0,1,0,1,0,0,1,0,1,1, each 832 clocks.
  - `tx_done` pulses once, 8320 clocks after the start edge.
- **Burst and overflow.** Divisor 1; write 0x00..0x11 on 18 consecutive clocks.
  - 0x00 is popped immediately; `count` reaches 16 and `full`=1.
  - 0x11 is dropped and `overflow`=1.
  - Line carries 0x00..0x10 (17 frames, 161 clocks apart); `empty`=1 afterwards.
- **Divisor change.** Divisor 1; write 0x3C and 0xC3. During the first frame set divisor 2 -> first frame uses 16-clock bits, second frame 32-clock bits.
- **Divisor zero.** Divisor 0; write 0xFF -> 16-clock bits, identical to divisor 1.
- **Reset mid-frame.** Write 0x55 and 0xAA; assert `rst` during DATA of the first frame.
  - `uart_tx`=1 immediately and `count`=0.
  - After release, no frame is transmitted and no `tx_done` occurs.
